// File: rtl/filter_round_sat_mc_pkg.sv
// Shared definitions for the multi-channel filter round/saturate output stage.
//   RND_*    : encodings of the rounding-mode config field (11 behaves as truncate)
//   ch_bits  : width of a channel tag for a given channel count (never below 1)
package filter_rt_pkg;

  localparam logic [1:0] RND_TRUNC     = 2'b00;
  localparam logic [1:0] RND_HALF_UP   = 2'b01;
  localparam logic [1:0] RND_HALF_EVEN = 2'b10;

  function automatic int ch_bits(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/filter_round_sat_mc_ovf_flag_counter.sv
// One channel's overflow bookkeeping: a sticky flag plus a saturating counter.
//   clk, rstb : clock, async active-low reset
//   set       : an overflowing sample of this channel is being registered
//   clr       : one-cycle clear of flag and counter
//   flag      : sticky overflow flag
//   cnt       : overflow count, sticks at all-ones
// A set arriving together with a clear restarts the count at one.
module ovf_flag_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             set,
  input  logic             clr,
  output logic             flag,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      flag <= 1'b0;
      cnt  <= '0;
    end else if (set) begin
      flag <= 1'b1;
      if (clr)
        cnt <= CNT_W'(1);
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
    end else if (clr) begin
      flag <= 1'b0;
      cnt  <= '0;
    end
  end

endmodule

// File: rtl/filter_round_sat_mc.sv
// Multi-channel filter output stage: rounds a wide signed accumulator sample by a
// programmable right shift, then saturates or wraps it to OUT_W bits and emits it
// through a 2-stage valid/ready pipeline. Keeps per-channel overflow flag/counter.
//   clk, rstb          : clock, async active-low reset
//   in_valid/in_ready  : input handshake; in_ch tags acc_in with its channel
//   rf_sat/rf_shift/rf_rnd_mode : config, captured with each accepted sample
//   trig_ovf_clear     : per-channel one-cycle clear of overflow flag/counter
//   out_valid/out_ready: output handshake; out_ch, filter_out carry the sample
//   ro_ovf_flag        : sticky per-channel overflow flags
//   ro_ovf_cnt         : per-channel saturating counters, channel c at [c*CNT_W +: CNT_W]
module filter_round_sat_mc
  import filter_rt_pkg::*;
#(
  parameter  int ACC_W      = 40,
  parameter  int OUT_W      = 16,
  parameter  int SHIFT_W    = 3,
  parameter  int SHIFT_BASE = 12,
  parameter  int NCH        = 4,
  parameter  int CNT_W      = 8,
  localparam int CH_W       = ch_bits(NCH)
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH_W-1:0]      in_ch,
  input  logic [ACC_W-1:0]     acc_in,
  input  logic                 rf_sat,
  input  logic [SHIFT_W-1:0]   rf_shift,
  input  logic [1:0]           rf_rnd_mode,
  input  logic [NCH-1:0]       trig_ovf_clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_ch,
  output logic [OUT_W-1:0]     filter_out,
  output logic [NCH-1:0]       ro_ovf_flag,
  output logic [NCH*CNT_W-1:0] ro_ovf_cnt
);

  // Wide enough to hold SHIFT_BASE + max(rf_shift) and to index acc_in.
  localparam int N_W = $clog2(SHIFT_BASE + (1 << SHIFT_W) + ACC_W) + 1;

  localparam logic signed [ACC_W:0] Q_MAX =
    $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] Q_MIN =
    $signed({{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  logic en1, en2;

  logic                s1_valid;
  logic signed [ACC_W:0] s1_sum;
  logic [N_W-1:0]      s1_n;
  logic                s1_sat;
  logic [CH_W-1:0]     s1_ch;

  // ---------------- handshake ----------------
  assign en2      = !out_valid || out_ready;
  assign en1      = en2 || !s1_valid;
  assign in_ready = en1;

  // ---------------- stage 1: add rounding constant ----------------
  logic [N_W-1:0]        n_in;
  logic [ACC_W:0]        half;
  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] rnd_c;
  logic signed [ACC_W:0] sum_in;

  assign n_in    = N_W'(SHIFT_BASE) + N_W'(rf_shift);
  assign half    = {{ACC_W{1'b0}}, 1'b1} << (n_in - N_W'(1));
  assign acc_ext = $signed({acc_in[ACC_W-1], acc_in});

  always_comb begin
    rnd_c = '0;
    case (rf_rnd_mode)
      RND_HALF_UP:   rnd_c = $signed(half);
      // Bias down by one unless the surviving LSB is odd: ties go to even.
      RND_HALF_EVEN: rnd_c = $signed(half - {{ACC_W{1'b0}}, 1'b1}
                                          + {{ACC_W{1'b0}}, acc_in[n_in]});
      default:       rnd_c = '0;
    endcase
  end

  // Extra headroom bit means the sum can never overflow.
  assign sum_in = acc_ext + rnd_c;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_n     <= '0;
      s1_sat   <= 1'b0;
      s1_ch    <= '0;
    end else if (en1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum <= sum_in;
        s1_n   <= n_in;
        s1_sat <= rf_sat;
        s1_ch  <= in_ch;
      end
    end
  end

  // ---------------- stage 2: shift, range check, saturate/wrap ----------------
  logic signed [ACC_W:0] q;
  logic                  ovf_hi, ovf_lo, ovf;
  logic [OUT_W-1:0]      res;

  assign q      = s1_sum >>> s1_n;
  assign ovf_hi = q > Q_MAX;
  assign ovf_lo = q < Q_MIN;
  assign ovf    = ovf_hi || ovf_lo;

  always_comb begin
    res = q[OUT_W-1:0];
    if (ovf && s1_sat)
      res = ovf_hi ? SAT_POS : SAT_NEG;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      filter_out <= '0;
    end else if (en2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_ch     <= s1_ch;
        filter_out <= res;
      end
    end
  end

  // ---------------- per-channel overflow bookkeeping ----------------
  // Counted when an overflowing sample is loaded into the output register;
  // tags outside 0..NCH-1 never match and so update nothing.
  for (genvar c = 0; c < NCH; c++) begin : g_ovf
    logic ovf_set;
    assign ovf_set = en2 && s1_valid && ovf && (s1_ch == CH_W'(c));

    ovf_flag_counter #(.CNT_W(CNT_W)) u_ovf (
      .clk  (clk),
      .rstb (rstb),
      .set  (ovf_set),
      .clr  (trig_ovf_clear[c]),
      .flag (ro_ovf_flag[c]),
      .cnt  (ro_ovf_cnt[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_filter_round_sat_mc.sv
// Self-checking bench for filter_round_sat_mc with default parameters.
// Expected samples come from an arithmetic model (integer add + arithmetic shift
// + range clamp) held in a queue; overflow counters are modelled per channel.
module tb_filter_round_sat_mc;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_ch = '0;
  logic [39:0] acc_in = '0;
  logic        rf_sat = 1'b0;
  logic [2:0]  rf_shift = '0;
  logic [1:0]  rf_rnd_mode = '0;
  logic [3:0]  trig_ovf_clear = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_ch;
  logic [15:0] filter_out;
  logic [3:0]  ro_ovf_flag;
  logic [31:0] ro_ovf_cnt;

  always #5 clk = ~clk;

  filter_round_sat_mc dut (
    .clk            (clk),
    .rstb           (rstb),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ch          (in_ch),
    .acc_in         (acc_in),
    .rf_sat         (rf_sat),
    .rf_shift       (rf_shift),
    .rf_rnd_mode    (rf_rnd_mode),
    .trig_ovf_clear (trig_ovf_clear),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ch         (out_ch),
    .filter_out     (filter_out),
    .ro_ovf_flag    (ro_ovf_flag),
    .ro_ovf_cnt     (ro_ovf_cnt)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] val;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t expq[$];
  int   mcnt[4];
  bit   mflag[4];
  bit   acc_flag;
  bit   use_k = 1'b0;
  logic [15:0] k_val = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value = floor((acc + R) / 2^n), then clamp or keep the low 16 bits.
  function automatic logic [15:0] model(input longint acc, input int n,
                                        input logic [1:0] mode, input bit sat,
                                        output bit ovf);
    longint r, q;
    r = 0;
    if (mode == 2'b01)
      r = longint'(1) << (n - 1);
    else if (mode == 2'b10)
      r = (longint'(1) << (n - 1)) - 1 + ((acc >>> n) & 1);
    q   = (acc + r) >>> n;
    ovf = (q > 32767) || (q < -32768);
    if (ovf && sat)
      return (q > 0) ? 16'h7FFF : 16'h8000;
    return q[15:0];
  endfunction

  function automatic logic [39:0] rand_acc();
    logic [63:0] r;
    longint s;
    r = {$urandom, $urandom};
    s = $signed(r) >>> $urandom_range(24, 40);
    return s[39:0];
  endfunction

  // One clock: checks in_ready and the presented output at negedge, scores
  // transfers, then steps to 1 time unit after the next rising edge.
  task automatic cycle();
    exp_t e;
    bit ovf;
    logic [15:0] v;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(!(expq.size() == 2 && !out_ready)));
    acc_flag = 1'b0;
    if (out_valid) begin
      if (expq.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        e = expq[0];
        chk("out_ch", 64'(out_ch), 64'(e.ch));
        chk("filter_out", 64'(filter_out), 64'(e.val));
        if (out_ready) void'(expq.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      v = model(longint'($signed(acc_in)), 12 + int'(rf_shift), rf_rnd_mode, rf_sat, ovf);
      e.ch  = in_ch;
      e.val = use_k ? k_val : v;
      expq.push_back(e);
      acc_flag = 1'b1;
      if (ovf) begin
        mflag[in_ch] = 1'b1;
        if (mcnt[in_ch] < 255) mcnt[in_ch]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && expq.size() > 0; i++) cycle();
    chk("drain_empty", 64'(expq.size()), 64'(0));
  endtask

  task automatic send(input logic [1:0] ch, input logic [39:0] acc, input bit sat,
                      input logic [2:0] sh, input logic [1:0] mode);
    in_ch = ch; acc_in = acc; rf_sat = sat; rf_shift = sh; rf_rnd_mode = mode;
    in_valid = 1'b1;
    acc_flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (acc_flag) break;
    end
    chk("accept", 64'(acc_flag), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic send_k(input logic [1:0] ch, input logic [39:0] acc, input bit sat,
                        input logic [2:0] sh, input logic [1:0] mode, input logic [15:0] k);
    use_k = 1'b1;
    k_val = k;
    send(ch, acc, sat, sh, mode);
    use_k = 1'b0;
  endtask

  task automatic chk_cnts();
    for (int c = 0; c < 4; c++) begin
      chk("ovf_flag", 64'(ro_ovf_flag[c]), 64'(mflag[c]));
      chk("ovf_cnt", 64'(ro_ovf_cnt[c*8 +: 8]), 64'(mcnt[c]));
    end
  endtask

  task automatic clear(input logic [3:0] mask);
    in_valid = 1'b0;
    trig_ovf_clear = mask;
    cycle();
    trig_ovf_clear = '0;
    for (int c = 0; c < 4; c++)
      if (mask[c]) begin mflag[c] = 1'b0; mcnt[c] = 0; end
  endtask

  task automatic stream(input int nsamp);
    int sent;
    sent = 0;
    for (int i = 0; i < nsamp * 10 && sent < nsamp; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_ch       = 2'($urandom_range(0, 3));
        acc_in      = rand_acc();
        rf_sat      = 1'($urandom_range(0, 1));
        rf_shift    = 3'($urandom_range(0, 7));
        rf_rnd_mode = 2'($urandom_range(0, 3));
        in_valid    = 1'b1;
      end
      cycle();
      if (acc_flag) begin sent++; in_valid = 1'b0; end
    end
    chk("stream_sent", 64'(sent), 64'(nsamp));
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    for (int c = 0; c < 4; c++) begin mcnt[c] = 0; mflag[c] = 1'b0; end

    // reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_ch", 64'(out_ch), 64'(0));
    chk("rst_filter_out", 64'(filter_out), 64'(0));
    chk("rst_flags", 64'(ro_ovf_flag), 64'(0));
    chk("rst_cnts", 64'(ro_ovf_cnt), 64'(0));
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;

    // rounding, n = 12
    send_k(2'd0, 40'h800,  1'b1, 3'd0, 2'b01, 16'h0001);
    send_k(2'd1, 40'h7FF,  1'b1, 3'd0, 2'b01, 16'h0000);
    send_k(2'd2, 40'h1800, 1'b1, 3'd0, 2'b10, 16'h0002);
    send_k(2'd3, 40'h2800, 1'b1, 3'd0, 2'b10, 16'h0002);
    send_k(2'd0, -40'sh800, 1'b0, 3'd0, 2'b00, 16'hFFFF);
    drain();
    chk_cnts();

    // saturation and wrap
    send_k(2'd1, 40'h800_0000, 1'b1, 3'd0, 2'b00, 16'h7FFF);
    drain();
    chk("sat_flag1", 64'(ro_ovf_flag[1]), 64'(1));
    chk("sat_cnt1", 64'(ro_ovf_cnt[15:8]), 64'(1));
    send_k(2'd1, -40'sh800_1000, 1'b1, 3'd0, 2'b00, 16'h8000);
    send_k(2'd1, 40'h800_0000,  1'b0, 3'd0, 2'b00, 16'h8000);
    drain();
    chk_cnts();
    clear(4'hF);
    chk_cnts();

    // config change between back-to-back accepts (n = 12, then n = 15)
    out_ready = 1'b1;
    in_ch = 2'd3; acc_in = 40'h0_1234_5678; rf_sat = 1'b1; rf_rnd_mode = 2'b01;
    rf_shift = 3'd0; in_valid = 1'b1;
    cycle();
    chk("cfg_acc0", 64'(acc_flag), 64'(1));
    rf_shift = 3'd3;
    cycle();
    chk("cfg_acc1", 64'(acc_flag), 64'(1));
    drain();

    // randomized traffic with random backpressure
    stream(10);
    stream(60);
    chk_cnts();

    // 300 overflows on channel 2; other channels keep their counts
    clear(4'b0100);
    out_ready = 1'b1;
    in_ch = 2'd2; acc_in = 40'h4000_0000; rf_shift = 3'd0; rf_rnd_mode = 2'b00;
    sent = 0;
    for (int i = 0; i < 400 && sent < 300; i++) begin
      rf_sat = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      cycle();
      if (acc_flag) sent++;
    end
    in_valid = 1'b0;
    drain();
    chk("cnt2_saturated", 64'(ro_ovf_cnt[23:16]), 64'(255));
    chk_cnts();

    // clear in the same cycle as an overflow load: set wins
    send(2'd2, 40'h4000_0000, 1'b1, 3'd0, 2'b00);
    trig_ovf_clear = 4'b0100;
    cycle();
    trig_ovf_clear = '0;
    mflag[2] = 1'b1;
    mcnt[2]  = 1;
    drain();
    chk("collide_flag2", 64'(ro_ovf_flag[2]), 64'(1));
    chk("collide_cnt2", 64'(ro_ovf_cnt[23:16]), 64'(1));
    chk_cnts();

    // async reset with two samples in flight
    out_ready = 1'b0;
    send(2'd0, 40'h0_0001_2345, 1'b1, 3'd1, 2'b01);
    send(2'd1, 40'h80_0000_0000, 1'b1, 3'd0, 2'b00);
    rstb = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_ch", 64'(out_ch), 64'(0));
    chk("arst_filter_out", 64'(filter_out), 64'(0));
    chk("arst_flags", 64'(ro_ovf_flag), 64'(0));
    chk("arst_cnts", 64'(ro_ovf_cnt), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    expq.delete();
    for (int c = 0; c < 4; c++) begin mcnt[c] = 0; mflag[c] = 1'b0; end
    #2;
    rstb = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_ch = 2'd3; acc_in = 40'h0_0000_5000; rf_sat = 1'b1; rf_shift = 3'd0;
    rf_rnd_mode = 2'b10; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("post_rst_accept", 64'(acc_flag), 64'(1));
    chk("post_rst_lat1", 64'(out_valid), 64'(0));
    cycle();
    chk("post_rst_lat2", 64'(out_valid), 64'(1));
    drain();
    chk_cnts();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filter_round_sat_mc.md
# filter_round_sat_mc

Parametrised, multi-channel successor to the filter output stage. It takes wide signed accumulator samples tagged with a channel index and applies a programmable right shift with selectable rounding. It then saturates or wraps the result to the output width and emits it through a 2-stage valid/ready pipeline. It sits between the time-multiplexed MAC accumulator and the output sample FIFO, and keeps a sticky overflow flag plus a saturating overflow counter per channel for the register file.

## Interface
Parameters:
- ACC_W, 40, accumulator input width (signed two's complement)
- OUT_W, 16, output sample width (signed)
- SHIFT_W, 3, width of rf_shift
- SHIFT_BASE, 12, fixed shift offset; effective shift n = SHIFT_BASE + rf_shift; requires 1 <= n <= ACC_W-1
- NCH, 4, channel count; CH_W = max(1, clog2(NCH))
- CNT_W, 8, per-channel overflow counter width

Ports:
- clk  in  1  clock
- rstb  in  1  reset: rstb, asynchronous, active-low; clock clk
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts a sample this cycle
- in_ch  in  CH_W  channel tag of input sample
- acc_in  in  ACC_W  signed accumulator value
- rf_sat  in  1  1 = saturate on overflow, 0 = wrap (keep low OUT_W bits)
- rf_shift  in  SHIFT_W  shift increment
- rf_rnd_mode  in  2  00 truncate (floor), 01 round half up, 10 round half to even, 11 treated as 00
- trig_ovf_clear  in  NCH  per-channel one-cycle clear of flag and counter
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_ch  out  CH_W  channel tag of output sample
- filter_out  out  OUT_W  rounded, saturated or wrapped sample
- ro_ovf_flag  out  NCH  sticky per-channel overflow flag
- ro_ovf_cnt  out  NCH*CNT_W  per-channel overflow counters, channel c at bits [c*CNT_W +: CNT_W]

## Operation
- Config is sampled with the data on acceptance (rf_sat, rf_shift, rf_rnd_mode) and carried through the pipeline. A mid-stream change affects only samples accepted afterwards.
- Stage 1: sign-extend acc_in to ACC_W+1 bits, then add a rounding constant R:
  - truncate: R = 0
  - half up: R = 2^(n-1)
  - half even: R = 2^(n-1) - 1 + acc_in[n]
- Stage 2: arithmetic right shift of the sum by n gives q (ACC_W+1-n bits).
  - Overflow when q > 2^(OUT_W-1)-1 or q < -2^(OUT_W-1).
  - On overflow with rf_sat=1: output is 2^(OUT_W-1)-1 for positive q and -2^(OUT_W-1) for negative q.
  - On overflow with rf_sat=0: output is q[OUT_W-1:0].
  - No overflow: output is q[OUT_W-1:0].
- Per channel c, flag and counter update on the edge that loads an overflowing sample of channel c into the output register:
  - flag <= 1
  - counter increments and saturates at 2^CNT_W-1 (no wrap)
- trig_ovf_clear[c] clears flag and counter of channel c.
  - If a clear and an overflow of channel c happen in the same cycle, the set wins: flag = 1, counter = 1.
- Channels are independent; in_ch >= NCH is passed through to out_ch but updates no flag or counter.

## Timing
- Reset values: in_ready=1 (combinational), out_valid=0, out_ch=0, filter_out=0, ro_ovf_flag=0, ro_ovf_cnt=0, internal stage valids=0.
- Handshake:
  - en2 = !out_valid | out_ready
  - en1 = en2 | !s1_valid
  - in_ready = en1
- Transfer on valid & ready; a stalled output holds out_valid, out_ch and filter_out stable.
- Latency: 2 cycles from input acceptance to out_valid with out_ready held high. Throughput is 1 sample/cycle. Order is preserved, with no drops or duplicates under any out_ready pattern.
- Async reset mid-operation discards all in-flight samples; the output returns to reset values immediately.

## Structure
- Package filter_rt_pkg: rounding mode localparams (RND_TRUNC, RND_HALF_UP, RND_HALF_EVEN) and a function computing the CH_W bit count.
- Sub-module ovf_flag_counter (parameter CNT_W): a single sticky flag plus saturating counter with set/clear priority. Instantiated NCH times via generate.

## Test plan
All scenarios use default parameters.
- Rounding (rf_shift=0, n=12):
  - Mode 01: acc 0x800 -> 1, acc 0x7FF -> 0.
  - Mode 10: 0x1800 -> 2, 0x2800 -> 2.
  - Mode 00: -0x800 -> 0xFFFF.
- Saturation: acc = 2^27, rf_sat=1 -> 0x7FFF, flag[ch] set, cnt=1. acc = -(2^27+2^12), rf_sat=1 -> 0x8000. acc = 2^27, rf_sat=0 -> 0x8000.
- Backpressure: stream 10 samples across 4 channels with out_ready random 50% -> output order and values match a model, in_ready low only while both stages are full.
- Counter: 300 overflows on ch 2 -> cnt[2] = 255; clear asserted in the same cycle as an overflow -> flag=1, cnt=1; other channels unchanged.
- Config change mid-stream: rf_shift changes 0->3 between back-to-back accepts -> each sample uses the config it was accepted with (n=12 vs n=15).
- Reset: assert rstb low with 2 samples in flight -> out_valid=0, flags and counters cleared; the first post-reset sample emerges after 2 cycles.
